// File: rtl/seg_scan_mux_pkg.sv
// Shared seven-segment constants: hex glyphs, off patterns and scan phase type.
package seg_scan_mux_pkg;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}; index = nibble value (F first, 0 last).
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h71, // F
    7'h79, // E
    7'h5E, // d
    7'h39, // C
    7'h7C, // b
    7'h77, // A
    7'h6F, // 9
    7'h7F, // 8
    7'h07, // 7
    7'h7D, // 6
    7'h6D, // 5
    7'h66, // 4
    7'h4F, // 3
    7'h5B, // 2
    7'h06, // 1
    7'h3F  // 0
  };

  // All-segments-off pin patterns for each polarity.
  localparam logic [7:0] SEG_OFF_AL = 8'hFF;
  localparam logic [7:0] SEG_OFF_AH = 8'h00;

  // Per-slot phase: outputs dark during BLANK, digit driven during DRIVE.
  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble -> active-high 7-segment glyph {g,f,e,d,c,b,a}.
module seg_hex_decode
  import seg_scan_mux_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  // Table lookup covers 0-9 and A-F.
  always_comb begin
    glyph = SEG_GLYPH[nibble];
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment scanner with per-slot blanking and frame-aligned,
// double-buffered digit loads.
module seg_scan_mux
  import seg_scan_mux_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SLOT_CYCLES  = 25000,
  parameter int BLANK_CYCLES = 500,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     en_in,
  input  logic                  load,
  output logic                  frame_tick,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     sel_out
);

  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  // A zero-length blank window means every slot starts straight in DRIVE.
  localparam phase_t SLOT_START = (BLANK_CYCLES == 0) ? PH_DRIVE : PH_BLANK;

  localparam logic [7:0]        SEG_OFF = ACTIVE_LOW ? SEG_OFF_AL : SEG_OFF_AH;
  localparam logic [DIGITS-1:0] SEL_OFF = ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  phase_t           phase, phase_nxt;

  logic             cnt_wrap;
  logic             boundary;

  // Pending bank (written by load) and active bank (what the scan shows).
  logic [DIGITS-1:0][3:0] pend_val, act_val;
  logic [DIGITS-1:0]      pend_dp,  act_dp;
  logic [DIGITS-1:0]      pend_en,  act_en;
  logic                   pend_vld;

  logic [6:0]        glyph;
  logic [7:0]        drv_seg;
  logic [DIGITS-1:0] drv_sel;

  assign cnt_wrap = (cnt == CNT_LAST);
  assign boundary = cnt_wrap && (idx == IDX_LAST);

  // Slot counter and digit index; idx advances on each slot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt_wrap) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Phase state register.
  always_ff @(posedge clk) begin
    if (rst) phase <= SLOT_START;
    else     phase <= phase_nxt;
  end

  // Phase next-state: BLANK -> DRIVE after the blank window, back to slot start on wrap.
  always_comb begin
    phase_nxt = phase;
    if (cnt_wrap)
      phase_nxt = SLOT_START;
    else if ((BLANK_CYCLES > 0) && (cnt == BLANK_LAST))
      phase_nxt = PH_DRIVE;
  end

  // Double buffer: a boundary load bypasses pending so no stale copy lingers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_val <= '0;
      pend_dp  <= '0;
      pend_en  <= '0;
      pend_vld <= 1'b0;
      act_val  <= '0;
      act_dp   <= '0;
      act_en   <= '0;
    end else if (boundary) begin
      pend_vld <= 1'b0;
      if (load) begin
        act_val <= value_in;
        act_dp  <= dp_in;
        act_en  <= en_in;
      end else if (pend_vld) begin
        act_val <= pend_val;
        act_dp  <= pend_dp;
        act_en  <= pend_en;
      end
    end else if (load) begin
      pend_val <= value_in;
      pend_dp  <= dp_in;
      pend_en  <= en_in;
      pend_vld <= 1'b1;
    end
  end

  seg_hex_decode u_dec (
    .nibble (act_val[idx]),
    .glyph  (glyph)
  );

  // Active-high drive pattern for the current slot; dark when blanking or disabled.
  always_comb begin
    drv_sel = '0;
    drv_seg = '0;
    if ((phase == PH_DRIVE) && act_en[idx]) begin
      drv_sel[idx] = 1'b1;
      drv_seg      = {act_dp[idx], glyph};
    end
  end

  // Registered pins with board polarity applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out    <= SEG_OFF;
      sel_out    <= SEL_OFF;
      frame_tick <= 1'b0;
    end else begin
      seg_out    <= ACTIVE_LOW ? ~drv_seg : drv_seg;
      sel_out    <= ACTIVE_LOW ? ~drv_sel : drv_sel;
      frame_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomized bench for seg_scan_mux against a time-indexed reference model.
module tb_seg_scan_mux;

  localparam int DIGITS = 4;
  localparam int SLOT   = 8;
  localparam int BLANK  = 2;
  localparam int FRAME  = SLOT * DIGITS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  en_in = '0;
  logic        load = 1'b0;
  logic        frame_tick;
  logic [7:0]  seg_out;
  logic [3:0]  sel_out;

  int checks = 0;
  int failures = 0;

  seg_scan_mux #(
    .DIGITS       (DIGITS),
    .SLOT_CYCLES  (SLOT),
    .BLANK_CYCLES (BLANK),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .en_in      (en_in),
    .load       (load),
    .frame_tick (frame_tick),
    .seg_out    (seg_out),
    .sel_out    (sel_out)
  );

  always #5 clk = ~clk;

  // Standard hex glyphs {g,f,e,d,c,b,a}, active-high.
  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: time since reset determines slot/digit; banks follow frame rules.
  int          t;
  logic [15:0] m_aval, m_pval;
  logic [3:0]  m_aen, m_adp, m_pen, m_pdp;
  bit          m_pend;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_sel;
  logic        exp_tick;
  int          seen_1234;

  always @(posedge clk) begin
    int c, i;
    bit bnd;
    logic [3:0] nib;
    if (rst) begin
      t = 0; m_pend = 0;
      m_aval = '0; m_pval = '0; m_aen = '0; m_adp = '0; m_pen = '0; m_pdp = '0;
      exp_seg = 8'hFF; exp_sel = 4'hF; exp_tick = 1'b0;
    end else begin
      c   = t % SLOT;
      i   = (t / SLOT) % DIGITS;
      bnd = (t % FRAME) == FRAME - 1;
      exp_tick = bnd;
      exp_seg  = 8'hFF;
      exp_sel  = 4'hF;
      if (c >= BLANK && m_aen[i]) begin
        nib     = m_aval[4*i +: 4];
        exp_sel = ~(4'b0001 << i);
        exp_seg = ~{m_adp[i], glyph_tab[nib]};
      end
      if (bnd) begin
        if (load) begin
          m_aval = value_in; m_aen = en_in; m_adp = dp_in;
        end else if (m_pend) begin
          m_aval = m_pval; m_aen = m_pen; m_adp = m_pdp;
        end
        m_pend = 0;
      end else if (load) begin
        m_pval = value_in; m_pen = en_in; m_pdp = dp_in; m_pend = 1;
      end
      t++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // One cycle: check pins at negedge, then drive inputs for the next posedge.
  task automatic cyc(input bit ld, input logic [15:0] v, input logic [3:0] e, input logic [3:0] d);
    @(negedge clk);
    chk("sel", 32'(sel_out), 32'(exp_sel));
    chk("seg", 32'(seg_out), 32'(exp_seg));
    chk("tick", 32'(frame_tick), 32'(exp_tick));
    chk("sel_onehot", 32'($countones(~sel_out) <= 1), 32'd1);
    if (sel_out == 4'hE && seg_out[6:0] == ~7'h66 && seg_out[5] == 1'b0)
      seen_1234 = seen_1234;
    load = ld; value_in = v; en_in = e; dp_in = d;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, value_in, en_in, dp_in);
  endtask

  // Advance until the next posedge will process frame position p.
  task automatic align(input int p);
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (t % FRAME == p) return;
      cyc(0, value_in, en_in, dp_in);
    end
    chk("align_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    seen_1234 = 0;
    // 1. reset, no load: dark for 3 frames, ticks every 32 cycles
    rst = 1'b1;
    repeat (3) cyc(0, 16'h0, 4'h0, 4'h0);
    @(negedge clk);
    chk("rst_sel", 32'(sel_out), 32'hF);
    chk("rst_seg", 32'(seg_out), 32'hFF);
    chk("rst_tick", 32'(frame_tick), 32'h0);
    rst = 1'b0;
    idle(3 * FRAME);

    // 2. 1234 all enabled
    align(7);
    cyc(1, 16'h1234, 4'hF, 4'h0);
    idle(2 * FRAME);

    // 3. two loads within one frame; last wins
    align(5);
    cyc(1, 16'h1234, 4'hF, 4'h0);
    idle(4);
    cyc(1, 16'hABCD, 4'hF, 4'h0);
    idle(2 * FRAME);

    // 4. load exactly in the boundary cycle
    align(FRAME - 1);
    cyc(1, 16'h5678, 4'hF, 4'h0);
    idle(2 * FRAME + 3);

    // 5. digits 1 and 3 disabled, dp on digit 0
    cyc(1, 16'h9E07, 4'b0101, 4'b0001);
    idle(2 * FRAME);

    // randomized loads of data, enables and decimal points
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(9) == 0)
        cyc(1, 16'($urandom), 4'($urandom), 4'($urandom));
      else
        cyc(0, value_in, en_in, dp_in);
    end

    // 6. reset mid-DRIVE with a pending load; display must stay dark after release
    align(12);
    cyc(1, 16'h4321, 4'hF, 4'hF);
    rst = 1'b1;
    cyc(0, 16'h0, 4'h0, 4'h0);
    @(negedge clk);
    chk("midrst_sel", 32'(sel_out), 32'hF);
    chk("midrst_seg", 32'(seg_out), 32'hFF);
    rst = 1'b0;
    idle(2 * FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
